pair_sum_accumulator: RTL and testbench
=======================================

// Module: pair_sum_accumulator
// PURPOSE
//  Downstream consumer of the 4-bit counting stimulus stream (A, clk, rst).
//  - Samples A on each enabled posedge and adds it to the previous sample (registered W+1-bit sum).
//  - Accumulates every sum into a saturating accumulator.
//  - Optionally checks that A advances by exactly +1 (mod 2^W) per enabled sample, matching the generator's counter.
//  - Feeds the adder datapath under test and gives the bench a self-checking sink.
// PARAMETERS
//  W   4  operand width of A
//  AW  8  accumulator width; AW >= W+1
// PORTS
//  clk    in   1     clock, all state updates on posedge
//  rst    in   1     asynchronous, active-low reset
//  en     in   1     sample-valid; A is taken on posedge when en=1
//  clr    in   1     synchronous clear; has priority over en
//  A      in   W     operand stream
//  S      out  W+1   A + previous A, registered
//  S_vld  out  1     S updated on this edge (one-cycle pulse per pair)
//  ACC    out  AW    saturating running sum of all S values
//  ACC_sat out 1     sticky; set when ACC clamps
//  seq_err out 1     sticky; sequence violation detected
//  st     out  2     FSM state: IDLE=0, RUN=1, ERR=2
// BEHAVIOUR
//  - rst=0, asynchronous (no clock edge needed): S=0, S_vld=0, ACC=0, ACC_sat=0, seq_err=0, st=IDLE, a_prev=0.
//  - Priority each posedge: clr > en > hold.
//  - clr=1: ACC, ACC_sat, seq_err, S, S_vld -> 0; st -> IDLE.
//  - en=0 (no clr): all registers hold; S_vld -> 0.
//  - IDLE + en: a_prev <= A; st -> RUN; no sum yet, S_vld stays 0.
//  - RUN/ERR + en:
//    - S <= A + a_prev, zero-extended to W+1 bits (no truncation); S_vld <= 1.
//    - ACC <= min(ACC + (A + a_prev), 2^AW-1), computed on the same edge as S.
//    - ACC_sat <= 1 on clamp; ACC then stays at 2^AW-1 until clr/rst.
//    - a_prev <= A.
//  - Latency: S/ACC reflect the pair sampled at edge n on edge n (registered outputs, valid after edge n).
//  - Wrap-around: a_prev = 2^W-1 followed by A = 0 is a legal +1 step.
//  - ERR: datapath keeps running exactly as in RUN. Leave ERR only via clr or rst.
//  - Burst: back-to-back en every cycle is supported; gaps in en do not break the pair chain.
// CONFIGURATION
//  PAIR_SUM_SEQCHK_EN
//  - Defined:
//    - In RUN with en, if A != (a_prev+1) mod 2^W: seq_err <= 1 and st -> ERR on that edge.
//    - The sum is still produced on that edge.
//  - Undefined: seq_err is tied to 0; ERR state is never entered; st stays in {IDLE, RUN}.
// TESTING (W=4, AW=8)
//  1. Reset, then en=1 with A=0,1,2,3 ->
//     - S_vld=0 at edge 1;
//     - S=1,3,5 at edges 2-4;
//     - ACC=1,4,9; st=RUN; seq_err=0.
//  2. A=14,15,0,1 ->
//     - S=5'h1D, then 15, then 1;
//     - seq_err=0 (wrap is legal).
//  3. A=3 then 5 (macro defined) ->
//     - S=8, seq_err=1, st=ERR on edge 2.
//     - Subsequent A=6 -> S=11, seq_err stays 1.
//  4. Free-running counter for 40 samples ->
//     - ACC clamps at 255, ACC_sat=1;
//     - further sums leave ACC=255.
//  5. clr=1 and en=1 on the same edge ->
//     - ACC=0, S_vld=0, st=IDLE.
//     - The next en sample produces no S (S_vld=0).
//  6. rst driven low mid-run between clock edges ->
//     - all outputs 0 immediately;
//     - after release, the first en sample behaves as in IDLE.

Source files
------------

// File: rtl/pair_sum_accumulator.sv
// pair_sum_accumulator
//   Sink for a W-bit counting stream. Each enabled sample is added to the
//   previous sample. The registered (W+1)-bit pair sum is folded into a
//   saturating AW-bit running accumulator.
//   Optional feature macro: PAIR_SUM_SEQCHK_EN. When it is defined, the block
//   flags any sample that is not the previous sample + 1 (mod 2^W). It then
//   parks the FSM in ERR until clr or rst.
module pair_sum_accumulator #(
    parameter int W  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  A,
    output logic [W:0]    S,
    output logic          S_vld,
    output logic [AW-1:0] ACC,
    output logic          ACC_sat,
    output logic          seq_err,
    output logic [1:0]    st
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        st_q, st_d;
    logic [W-1:0]  a_prev_q, a_prev_d;
    logic [W:0]    s_q, s_d;
    logic          s_vld_q, s_vld_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          acc_sat_q, acc_sat_d;
`ifdef PAIR_SUM_SEQCHK_EN
    logic          seq_err_q, seq_err_d;
`endif

    logic [W:0]    pair_sum;
    logic [AW:0]   acc_next;

    // Saturating accumulate: returns {clamped, result}. The result is pinned at
    // 2^AW-1 whenever the true sum does not fit.
    function automatic logic [AW:0] sat_add(input logic [AW-1:0] acc_in,
                                            input logic [W:0]    inc);
        logic [AW:0] wide;
        wide = {1'b0, acc_in} + {{(AW-W){1'b0}}, inc};
        if (wide[AW]) begin
            sat_add = {1'b1, {AW{1'b1}}};
        end else begin
            sat_add = {1'b0, wide[AW-1:0]};
        end
    endfunction

    // Pair sum is zero-extended so the carry out of the W-bit add is kept.
    assign pair_sum = {1'b0, A} + {1'b0, a_prev_q};
    assign acc_next = sat_add(acc_q, pair_sum);

    // Next-state and datapath update: priority is clr, then en, then hold.
    always_comb begin
        st_d      = st_q;
        a_prev_d  = a_prev_q;
        s_d       = s_q;
        s_vld_d   = 1'b0;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
`ifdef PAIR_SUM_SEQCHK_EN
        seq_err_d = seq_err_q;
`endif
        if (clr) begin
            st_d      = IDLE;
            s_d       = '0;
            acc_d     = '0;
            acc_sat_d = 1'b0;
`ifdef PAIR_SUM_SEQCHK_EN
            seq_err_d = 1'b0;
`endif
        end else if (en) begin
            a_prev_d = A;
            case (st_q)
                IDLE: begin
                    // First sample after reset/clear only seeds the pair chain.
                    st_d = RUN;
                end
                RUN, ERR: begin
                    s_d       = pair_sum;
                    s_vld_d   = 1'b1;
                    acc_d     = acc_next[AW-1:0];
                    acc_sat_d = acc_sat_q | acc_next[AW];
`ifdef PAIR_SUM_SEQCHK_EN
                    // Wrap from 2^W-1 to 0 is a legal step because the compare is mod 2^W.
                    if ((st_q == RUN) && (A != (a_prev_q + W'(1)))) begin
                        seq_err_d = 1'b1;
                        st_d      = ERR;
                    end
`endif
                end
                default: begin
                    st_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= IDLE;
            a_prev_q  <= '0;
            s_q       <= '0;
            s_vld_q   <= 1'b0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
`ifdef PAIR_SUM_SEQCHK_EN
            seq_err_q <= 1'b0;
`endif
        end else begin
            st_q      <= st_d;
            a_prev_q  <= a_prev_d;
            s_q       <= s_d;
            s_vld_q   <= s_vld_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
`ifdef PAIR_SUM_SEQCHK_EN
            seq_err_q <= seq_err_d;
`endif
        end
    end

    assign S       = s_q;
    assign S_vld   = s_vld_q;
    assign ACC     = acc_q;
    assign ACC_sat = acc_sat_q;
    assign st      = st_q;
`ifdef PAIR_SUM_SEQCHK_EN
    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_pair_sum_accumulator.sv
// Directed bench for pair_sum_accumulator (W=4, AW=8).
module tb_pair_sum_accumulator;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] A;
    logic [4:0] S;
    logic       S_vld;
    logic [7:0] ACC;
    logic       ACC_sat;
    logic       seq_err;
    logic [1:0] st;

    int checks = 0;
    int errors = 0;

    pair_sum_accumulator #(.W(4), .AW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .A       (A),
        .S       (S),
        .S_vld   (S_vld),
        .ACC     (ACC),
        .ACC_sat (ACC_sat),
        .seq_err (seq_err),
        .st      (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic e, input logic c, input logic [3:0] a);
        en  = e;
        clr = c;
        A   = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cnt;
        rst = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        A   = 4'd0;
        #2;
        chk("rst_S", S, 0);
        chk("rst_S_vld", S_vld, 0);
        chk("rst_ACC", ACC, 0);
        chk("rst_ACC_sat", ACC_sat, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_st", st, 0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: counting 0..3
        step(1, 0, 4'd0);
        chk("t1_e1_vld", S_vld, 0);
        chk("t1_e1_st", st, 1);
        step(1, 0, 4'd1);
        chk("t1_e2_S", S, 1);
        chk("t1_e2_vld", S_vld, 1);
        chk("t1_e2_ACC", ACC, 1);
        step(1, 0, 4'd2);
        chk("t1_e3_S", S, 3);
        chk("t1_e3_ACC", ACC, 4);
        step(1, 0, 4'd3);
        chk("t1_e4_S", S, 5);
        chk("t1_e4_ACC", ACC, 9);
        chk("t1_st", st, 1);
        chk("t1_seq_err", seq_err, 0);

        // Test 2: wrap-around 14,15,0,1 then a gap in en
        step(0, 1, 4'd0);
        chk("t2_clr_ACC", ACC, 0);
        chk("t2_clr_st", st, 0);
        chk("t2_clr_S", S, 0);
        step(1, 0, 4'd14);
        chk("t2_e1_vld", S_vld, 0);
        step(1, 0, 4'd15);
        chk("t2_S_1D", S, 5'h1D);
        chk("t2_ACC_29", ACC, 29);
        step(1, 0, 4'd0);
        chk("t2_S_15", S, 15);
        chk("t2_ACC_44", ACC, 44);
        step(1, 0, 4'd1);
        chk("t2_S_1", S, 1);
        chk("t2_ACC_45", ACC, 45);
        chk("t2_seq_err", seq_err, 0);
        chk("t2_st", st, 1);
        step(0, 0, 4'd9);
        chk("t2_gap_vld", S_vld, 0);
        chk("t2_gap_S", S, 1);
        chk("t2_gap_ACC", ACC, 45);
        step(1, 0, 4'd2);
        chk("t2_after_gap_S", S, 3);
        chk("t2_after_gap_ACC", ACC, 48);

        // Test 3: sequence break 3 -> 5 -> 6
        step(0, 1, 4'd0);
        step(1, 0, 4'd3);
        step(1, 0, 4'd5);
        chk("t3_S_8", S, 8);
        chk("t3_vld", S_vld, 1);
`ifdef PAIR_SUM_SEQCHK_EN
        chk("t3_seq_err", seq_err, 1);
        chk("t3_st_err", st, 2);
`else
        chk("t3_seq_err", seq_err, 0);
        chk("t3_st_run", st, 1);
`endif
        step(1, 0, 4'd6);
        chk("t3_S_11", S, 11);
        chk("t3_ACC_19", ACC, 19);
`ifdef PAIR_SUM_SEQCHK_EN
        chk("t3_seq_err_sticky", seq_err, 1);
        chk("t3_st_err_stays", st, 2);
`else
        chk("t3_seq_err_tied", seq_err, 0);
        chk("t3_st_run_stays", st, 1);
`endif

        // Test 4: free-running counter, 40 samples, saturation
        step(0, 1, 4'd0);
        chk("t4_clr_seq_err", seq_err, 0);
        chk("t4_clr_st", st, 0);
        cnt = 4'd0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, cnt);
            cnt = cnt + 4'd1;
            if (i == 19) begin
                chk("t4_acc_before_clamp", ACC, 249);
                chk("t4_sat_before_clamp", ACC_sat, 0);
            end
            if (i == 20) begin
                chk("t4_acc_clamp", ACC, 255);
                chk("t4_sat_clamp", ACC_sat, 1);
            end
        end
        chk("t4_acc_final", ACC, 255);
        chk("t4_sat_final", ACC_sat, 1);
        chk("t4_S_last", S, 13);
        chk("t4_seq_err", seq_err, 0);

        // Test 5: clr and en together
        step(1, 1, 4'd8);
        chk("t5_ACC", ACC, 0);
        chk("t5_ACC_sat", ACC_sat, 0);
        chk("t5_vld", S_vld, 0);
        chk("t5_st", st, 0);
        step(1, 0, 4'd9);
        chk("t5_next_vld", S_vld, 0);
        chk("t5_next_st", st, 1);
        step(1, 0, 4'd10);
        chk("t5_S_19", S, 19);
        chk("t5_ACC_19", ACC, 19);

        // Test 6: asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("t6_S", S, 0);
        chk("t6_vld", S_vld, 0);
        chk("t6_ACC", ACC, 0);
        chk("t6_sat", ACC_sat, 0);
        chk("t6_seq_err", seq_err, 0);
        chk("t6_st", st, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 4'd11);
        chk("t6_first_vld", S_vld, 0);
        chk("t6_first_st", st, 1);
        chk("t6_first_S", S, 0);
        step(1, 0, 4'd12);
        chk("t6_S_23", S, 23);
        chk("t6_ACC_23", ACC, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
